regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port (addr/we/data) between NREQ writeback requesters
//  (e.g. ALU and load unit) using round-robin arbitration with a valid/ready handshake.

---
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 tb/tb_regfile_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a per-register busy scoreboard.
// Latency: the write is driven one cycle after the grant; a requester waits while hold=1 or while another requester is granted.
module regfile_write_arbiter #(
    parameter  int NREQ = 2,
    parameter  int AW   = 5,
    parameter  int DW   = 32,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_data,
    output logic [IW-1:0]        grant_id,
    output logic [(2**AW)-1:0]   busy
);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_found;
    logic               hs;
    logic [AW-1:0]      addr_arr [NREQ];
    logic [DW-1:0]      data_arr [NREQ];
    logic [(2**AW)-1:0] busy_nxt;

    // ptr is always < NREQ, so a single conditional subtract performs the wrap.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[rr_idx(ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(ptr, k);
            end
        end
    end

    // Gating with rst keeps ready low for the whole time reset is asserted.
    assign hs = rst & ~hold & gnt_found;

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    // A reservation landing in the same cycle as the write to that register wins.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)     busy_nxt[rf_addr]  = 1'b0;
        if (rsv_valid) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            grant_id <= '0;
            busy     <= '0;
        end else begin
            rf_we <= hs;
            busy  <= busy_nxt;
            if (hs) begin
                rf_addr  <= addr_arr[gnt_idx];
                rf_data  <= data_arr[gnt_idx];
                grant_id <= gnt_idx;
                ptr      <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and constrained-random checks of the register-file write arbiter (NREQ=2, AW=5, DW=32).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [1:0]  req_valid;
    logic [4:0]  a [2];
    logic [31:0] d [2];
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [0:0]  grant_id;
    logic [31:0] busy;

    int n_cmp = 0;
    int n_bad = 0;

    assign req_addr = {a[1], a[0]};
    assign req_data = {d[1], d[0]};

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model state for the random phase
    int          m_ptr;
    int          g;
    int          idx;
    int          starve [2];
    logic [1:0]  consumed;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_gid;
    logic [31:0] e_busy;

    initial begin
        rst = 1'b0; hold = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
        req_valid = 2'b11;
        a[0] = 5'd0; a[1] = 5'd0; d[0] = '0; d[1] = '0;
        tick(); tick();
        check("rst_we",    32'(rf_we),     0);
        check("rst_addr",  32'(rf_addr),   0);
        check("rst_data",  rf_data,        0);
        check("rst_gid",   32'(grant_id),  0);
        check("rst_busy",  busy,           0);
        check("rst_ready", 32'(req_ready), 0);

        req_valid = 2'b00;
        rst = 1'b1;
        tick();

        // single requester
        req_valid = 2'b01; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
        #1 check("single_ready", 32'(req_ready), 32'b01);
        tick();
        check("single_we",   32'(rf_we),    1);
        check("single_addr", 32'(rf_addr),  5);
        check("single_data", rf_data,       32'hDEADBEEF);
        check("single_gid",  32'(grant_id), 0);
        req_valid = 2'b00;
        #1 check("idle_ready", 32'(req_ready), 0);
        tick();
        check("idle_we",       32'(rf_we),   0);
        check("idle_addr_hold", 32'(rf_addr), 5);

        // requester 1 alone moves the pointer back to 0
        req_valid = 2'b10; a[1] = 5'd9; d[1] = 32'h99;
        #1 check("r1_ready", 32'(req_ready), 32'b10);
        tick();
        check("r1_gid",  32'(grant_id), 1);
        check("r1_addr", 32'(rf_addr),  9);

        // contention: 0,1,0,1 with no bubble
        req_valid = 2'b11; a[0] = 5'd10; d[0] = 32'hA0A0A0A0; a[1] = 5'd11; d[1] = 32'hB1B1B1B1;
        #1 check("cont_ready0", 32'(req_ready), 32'b01);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_we",   32'(rf_we),    1);
            check("cont_gid",  32'(grant_id), (k % 2 == 0) ? 0 : 1);
            check("cont_addr", 32'(rf_addr),  (k % 2 == 0) ? 10 : 11);
            check("cont_data", rf_data,       (k % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            if (k == 3) req_valid = 2'b00;
            #1 check("cont_ready", 32'(req_ready), (k == 3) ? 0 : ((k % 2 == 0) ? 32'b10 : 32'b01));
        end
        tick();
        check("cont_end_we", 32'(rf_we), 0);

        // hold: grant req0 first so req1 has priority once hold drops
        req_valid = 2'b01;
        #1 check("pre_hold_ready", 32'(req_ready), 32'b01);
        tick();
        check("pre_hold_gid", 32'(grant_id), 0);
        hold = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 check("hold_ready", 32'(req_ready), 0);
            tick();
            check("hold_we", 32'(rf_we), 0);
        end
        hold = 1'b0;
        #1 check("post_hold_ready", 32'(req_ready), 32'b10);
        tick();
        check("post_hold_we",  32'(rf_we),    1);
        check("post_hold_gid", 32'(grant_id), 1);
        req_valid = 2'b00;

        // scoreboard set then clear
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        tick();
        check("sb_set", busy, 32'h80);
        rsv_valid = 1'b0; req_valid = 2'b01; a[0] = 5'd7; d[0] = 32'h77;
        tick();
        check("sb_wr_we",   32'(rf_we),   1);
        check("sb_wr_addr", 32'(rf_addr), 7);
        check("sb_in_wr",   busy,         32'h80);
        req_valid = 2'b00;
        tick();
        check("sb_clear", busy, 0);

        // reservation in the write cycle survives
        rsv_valid = 1'b1;
        tick();
        check("sb_set2", busy, 32'h80);
        rsv_valid = 1'b0; req_valid = 2'b01;
        tick();
        check("sb_wr2_we", 32'(rf_we), 1);
        rsv_valid = 1'b1; req_valid = 2'b00;
        tick();
        check("sb_set_wins", busy, 32'h80);
        rsv_valid = 1'b0; req_valid = 2'b10; a[1] = 5'd0; d[1] = 32'h12345678;
        tick();
        check("r0_we",   32'(rf_we),    1);
        check("r0_addr", 32'(rf_addr),  0);
        check("r0_data", rf_data,       32'h12345678);
        check("r0_gid",  32'(grant_id), 1);
        req_valid = 2'b00;
        tick();
        check("r0_busy_kept", busy, 32'h80);

        // reset mid-grant
        req_valid = 2'b11; a[0] = 5'd1; d[0] = 32'h11; a[1] = 5'd2; d[1] = 32'h22;
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        #1 check("mr_ready0", 32'(req_ready), 32'b01);
        tick();
        check("mr_we",   32'(rf_we), 1);
        check("mr_busy", busy,       32'h88);
        rsv_valid = 1'b0;
        #1 check("mr_ready1", 32'(req_ready), 32'b10);
        rst = 1'b0;
        #1;
        check("mr_rst_we",    32'(rf_we),     0);
        check("mr_rst_busy",  busy,           0);
        check("mr_rst_ready", 32'(req_ready), 0);
        check("mr_rst_addr",  32'(rf_addr),   0);
        tick();
        check("mr_drop_we", 32'(rf_we), 0);
        rst = 1'b1;
        #1 check("mr_rel_ready", 32'(req_ready), 32'b01);
        tick();
        check("mr_rel_gid",  32'(grant_id), 0);
        check("mr_rel_addr", 32'(rf_addr),  1);
        check("mr_rel_data", rf_data,       32'h11);

        // random traffic against a reference model
        req_valid = 2'b00; hold = 1'b0; rsv_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_ptr = 0; e_we = 1'b0; e_addr = '0; e_data = '0; e_gid = 1'b0; e_busy = '0;
        starve[0] = 0; starve[1] = 0; consumed = 2'b00;
        for (int it = 0; it < 400; it++) begin
            check("rnd_we",   32'(rf_we),    32'(e_we));
            check("rnd_addr", 32'(rf_addr),  32'(e_addr));
            check("rnd_data", rf_data,       e_data);
            check("rnd_gid",  32'(grant_id), 32'(e_gid));
            check("rnd_busy", busy,          e_busy);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || consumed[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    a[i] = 5'($urandom_range(0, 7));
                    d[i] = $urandom();
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                    starve[i] = 0;
                end
            end
            consumed = 2'b00;
            hold = ($urandom_range(0, 5) == 0);
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            #1;
            g = -1;
            e_rdy = 2'b00;
            if (!hold) begin
                for (int k = 0; k < 2; k++) begin
                    idx = (m_ptr + k) % 2;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) e_rdy[g] = 1'b1;
            check("rnd_ready", 32'(req_ready), 32'(e_rdy));
            if (req_ready != 2'b00) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_ready[i]) starve[i] = 0;
                    else if (req_valid[i]) begin
                        starve[i]++;
                        check("rnd_starve", 32'(starve[i] <= 2), 1);
                    end
                end
            end
            if (e_we) e_busy[e_addr] = 1'b0;
            if (rsv_valid) e_busy[rsv_addr] = 1'b1;
            if (g >= 0) begin
                e_we = 1'b1; e_addr = a[g]; e_data = d[g]; e_gid = 1'(g);
                m_ptr = (g + 1) % 2;
                consumed[g] = 1'b1;
            end else begin
                e_we = 1'b0;
            end
            tick();
        end
        req_valid = 2'b00; hold = 1'b0; rsv_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
